// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, fetch step size and
// the prefetch FIFO entry layout.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory read port, decode valid/ready handshake
// and execute redirect. master = fetch unit, slave = memory/decode/execute side.
interface instr_fetch_unit_if;

    logic        fetchEn;
    logic [31:0] instrMemAddr;
    logic [31:0] instruction;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        fetchFault;

    modport master (
        input  fetchEn, instruction, instrReady, redirectValid, redirectPc,
        output instrMemAddr, instrValid, instrOut, instrPc, fetchFault
    );

    modport slave (
        output fetchEn, instruction, instrReady, redirectValid, redirectPc,
        input  instrMemAddr, instrValid, instrOut, instrPc, fetchFault
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries; head is a registered storage slot.
// Latency: push visible at head one cycle later. Push while full only with a same-cycle pop.
// Flush clears both pointers and overrides any push/pop in that cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wr_entry_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop_i)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, fetch FSM, redirect handling; optional misaligned-redirect trap under FETCH_MISALIGN_TRAP_EN.
// Latency: captured word is valid to decode one cycle after capture; 1 instr/cycle sustained.
// Backpressure: full prefetch FIFO without a pop stalls fetchPc and re-reads the same address.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  redirect_target;
    logic         misalign;
    logic         redirect_act;
    logic         pop, push;
    logic         fifo_full, fifo_empty;
    fetch_entry_t push_entry, head_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign        = (bus.redirectPc[1:0] != 2'b00);
    assign redirect_target = bus.redirectPc;
    assign bus.fetchFault  = (state_q == FAULT);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirectPc[1:0];
    assign misalign        = 1'b0;
    assign redirect_target = {bus.redirectPc[31:2], 2'b00};
    assign bus.fetchFault  = 1'b0;
`endif

    // Redirect outranks pop and push; FAULT ignores redirects entirely.
    assign redirect_act = bus.redirectValid && (state_q != FAULT);
    assign pop          = !fifo_empty && bus.instrReady && !redirect_act;
    assign push         = (state_q == FETCH) && bus.fetchEn && !redirect_act &&
                          (!fifo_full || pop);

    assign push_entry = '{pc: fetch_pc_q, instr: bus.instruction};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_act) begin
            if (misalign) state_d = FAULT;
            else          fetch_pc_d = redirect_target;
        end else begin
            case (state_q)
                IDLE:    if (bus.fetchEn)  state_d = FETCH;
                FETCH:   if (!bus.fetchEn) state_d = IDLE;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
            if (push) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (redirect_act),
        .wr_entry_i (push_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head_entry)
    );

    assign bus.instrMemAddr = fetch_pc_q;
    assign bus.instrValid   = !fifo_empty;
    assign bus.instrOut     = head_entry.instr;
    assign bus.instrPc      = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a
// queue-based reference model; a second instance starts at the top of the address space.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned FIFO_DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus_w ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign bus.instruction   = mem_word(bus.instrMemAddr);
    assign bus_w.instruction = mem_word(bus_w.instrMemAddr);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(FIFO_DEPTH)) dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w)
    );

    // Reference model: fetch pointer, enable/fault flags, prefetch queue.
    logic [31:0]  m_pc;
    bit           m_active;
    bit           m_fault;
    fetch_entry_t mq[$];

    task automatic model_reset();
        m_pc     = 32'h0;
        m_active = 0;
        m_fault  = 0;
        mq.delete();
    endtask

    task automatic model_update(input logic en, rdy, rv, input logic [31:0] rpc);
        bit popped, pushed;
        if (rv && !m_fault) begin
            mq.delete();
            if (TRAP && rpc[1:0] != 2'b00) m_fault = 1;
            else                           m_pc = {rpc[31:2], 2'b00};
        end else begin
            popped = (mq.size() != 0) && rdy;
            pushed = m_active && !m_fault && en &&
                     ((mq.size() < FIFO_DEPTH) || popped);
            if (popped) void'(mq.pop_front());
            if (pushed) begin
                mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            if (!m_fault) m_active = en;
        end
    endtask

    task automatic step(input logic en, rdy, rv, input logic [31:0] rpc);
        bus.fetchEn       = en;
        bus.instrReady    = rdy;
        bus.redirectValid = rv;
        bus.redirectPc    = rpc;
        @(posedge clock);
        model_update(en, rdy, rv, rpc);
        #1;
    endtask

    task automatic do_reset();
        bus.fetchEn = 0; bus.instrReady = 0; bus.redirectValid = 0; bus.redirectPc = 0;
        bus_w.fetchEn = 0; bus_w.instrReady = 0; bus_w.redirectValid = 0; bus_w.redirectPc = 0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.fetchEn = 0; bus.instrReady = 0; bus.redirectValid = 0; bus.redirectPc = 0;
        bus_w.fetchEn = 0; bus_w.instrReady = 0; bus_w.redirectValid = 0; bus_w.redirectPc = 0;
        reset = 1'b0;
        #12;
        n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.instrValid); else n_pass++;
        n_checks++; if (bus.instrOut !== 32'h0) $display("FAIL reset_instr got %h exp 0", bus.instrOut); else n_pass++;
        n_checks++; if (bus.instrPc !== 32'h0) $display("FAIL reset_pc got %h exp 0", bus.instrPc); else n_pass++;
        n_checks++; if (bus.instrMemAddr !== 32'h0) $display("FAIL reset_addr got %h exp 0", bus.instrMemAddr); else n_pass++;
        n_checks++; if (bus.fetchFault !== 1'b0) $display("FAIL reset_fault got %b exp 0", bus.fetchFault); else n_pass++;
        n_checks++; if (bus_w.instrMemAddr !== 32'hFFFF_FFFC) $display("FAIL reset_addr_w got %h exp fffffffc", bus_w.instrMemAddr); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        step(1, 1, 0, 0);
        n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL stream_first_valid got %b exp 0", bus.instrValid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPc !== 32'(4 * i))
                $display("FAIL stream_pc[%0d] got v=%b pc=%h exp v=1 pc=%h", i, bus.instrValid, bus.instrPc, 32'(4 * i));
            else n_pass++;
            n_checks++; if (bus.instrOut !== mem_word(32'(4 * i)))
                $display("FAIL stream_instr[%0d] got %h exp %h", i, bus.instrOut, mem_word(32'(4 * i)));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        n_checks++; if (bus.instrMemAddr !== 32'h8) $display("FAIL stall_addr got %h exp 8", bus.instrMemAddr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPc !== 32'(4 * i))
                $display("FAIL stall_drain[%0d] got v=%b pc=%h exp v=1 pc=%h", i, bus.instrValid, bus.instrPc, 32'(4 * i));
            else n_pass++;
            step(1, 1, 0, 0);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h40);
        n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL redir_valid got %b exp 0", bus.instrValid); else n_pass++;
        n_checks++; if (bus.instrMemAddr !== 32'h40) $display("FAIL redir_addr got %h exp 40", bus.instrMemAddr); else n_pass++;
        step(1, 0, 0, 0);
        n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPc !== 32'h40)
            $display("FAIL redir_target got v=%b pc=%h exp v=1 pc=40", bus.instrValid, bus.instrPc);
        else n_pass++;
        n_checks++; if (bus.instrOut !== mem_word(32'h40)) $display("FAIL redir_instr got %h exp %h", bus.instrOut, mem_word(32'h40)); else n_pass++;
    endtask

    task automatic test_misalign();
        step(1, 0, 1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (bus.fetchFault !== 1'b1) $display("FAIL mis_fault got %b exp 1", bus.fetchFault); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.instrValid !== 1'b0 || bus.instrMemAddr !== 32'h44)
                $display("FAIL mis_hold[%0d] got v=%b addr=%h exp v=0 addr=44", i, bus.instrValid, bus.instrMemAddr);
            else n_pass++;
            step(1, 1, (i % 3) == 0, 32'h80);
        end
        n_checks++; if (bus.fetchFault !== 1'b1) $display("FAIL mis_sticky got %b exp 1", bus.fetchFault); else n_pass++;
`else
        n_checks++; if (bus.fetchFault !== 1'b0) $display("FAIL mis_fault got %b exp 0", bus.fetchFault); else n_pass++;
        n_checks++; if (bus.instrValid !== 1'b0 || bus.instrMemAddr !== 32'h40)
            $display("FAIL mis_addr got v=%b addr=%h exp v=0 addr=40", bus.instrValid, bus.instrMemAddr);
        else n_pass++;
        step(1, 0, 0, 0);
        n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPc !== 32'h40)
            $display("FAIL mis_resume got v=%b pc=%h exp v=1 pc=40", bus.instrValid, bus.instrPc);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_checks++; if (bus.instrValid !== 1'b1) $display("FAIL areset_pre got %b exp 1", bus.instrValid); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL areset_valid got %b exp 0", bus.instrValid); else n_pass++;
        n_checks++; if (bus.instrMemAddr !== 32'h0) $display("FAIL areset_addr got %h exp 0", bus.instrMemAddr); else n_pass++;
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        bus_w.fetchEn    = 1;
        bus_w.instrReady = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        n_checks++; if (bus_w.instrValid !== 1'b1 || bus_w.instrPc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_first got v=%b pc=%h exp v=1 pc=fffffffc", bus_w.instrValid, bus_w.instrPc);
        else n_pass++;
        n_checks++; if (bus_w.instrMemAddr !== 32'h4) $display("FAIL wrap_addr got %h exp 4", bus_w.instrMemAddr); else n_pass++;
        bus_w.instrReady = 1;
        step(0, 0, 0, 0);
        n_checks++; if (bus_w.instrPc !== 32'h0 || bus_w.instrOut !== mem_word(32'h0))
            $display("FAIL wrap_second got pc=%h instr=%h exp pc=0 instr=%h", bus_w.instrPc, bus_w.instrOut, mem_word(32'h0));
        else n_pass++;
        bus_w.fetchEn    = 0;
        bus_w.instrReady = 0;
    endtask

    task automatic test_random();
        logic        en, rdy, rv;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom % 8) != 0;
            rdy = ($urandom % 3) != 0;
            rv  = ($urandom % 16) == 0;
            rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (($urandom % 10) == 0) rpc[1] = 1'b1;
            step(en, rdy, rv, rpc);
            n_checks++; if (bus.instrValid !== (mq.size() != 0))
                $display("FAIL rnd_valid[%0d] got %b exp %b", i, bus.instrValid, mq.size() != 0);
            else n_pass++;
            n_checks++; if (bus.instrMemAddr !== m_pc)
                $display("FAIL rnd_addr[%0d] got %h exp %h", i, bus.instrMemAddr, m_pc);
            else n_pass++;
            n_checks++; if (bus.fetchFault !== m_fault)
                $display("FAIL rnd_fault[%0d] got %b exp %b", i, bus.fetchFault, m_fault);
            else n_pass++;
            if (mq.size() != 0) begin
                n_checks++; if (bus.instrPc !== mq[0].pc || bus.instrOut !== mq[0].instr)
                    $display("FAIL rnd_head[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                             i, bus.instrPc, bus.instrOut, mq[0].pc, mq[0].instr);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit: the initiator on the instruction-memory read port. Holds the fetch PC, drives the word-aligned byte address into the combinational instruction memory, captures the returned word with its PC in a small prefetch FIFO, and presents it to decode over a valid/ready handshake. Redirects from execute (branch/jump) flush the FIFO and restart fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fetchEn  input  1  1 = fetch allowed; 0 = stop issuing new fetches
- instrMemAddr  output  32  byte address to instruction memory, always fetchPc
- instruction  input  32  word returned combinationally for instrMemAddr in the same cycle
- instrValid  output  1  FIFO head holds a valid instruction
- instrReady  input  1  decode accepts the head this cycle
- instrOut  output  32  head instruction word
- instrPc  output  32  head instruction PC
- redirectValid  input  1  execute requests a PC change
- redirectPc  input  32  redirect target
- fetchFault  output  1  sticky misaligned-target fault (see Configuration)

## Operation
- FSM states: IDLE, FETCH, FAULT.
  - IDLE: no capture. Goes to FETCH when fetchEn=1.
  - FETCH: captures data. Goes to IDLE when fetchEn=0, and to FAULT on a misaligned redirect (macro defined only).
  - FAULT: terminal until reset. No captures. Redirects ignored. The FIFO drains normally.
- Capture in FETCH: push {fetchPc, instruction} and set fetchPc += 4, when the FIFO is not full or a pop occurs the same cycle.
- fetchPc arithmetic is 32-bit and wraps from 32'hFFFF_FFFC to 0.
- Pop: instrValid & instrReady.
- Outputs are driven from FIFO storage registers, not from the instruction input.
- Redirect (any state except FAULT) has priority over every other event in the same cycle:
  - The FIFO is emptied.
  - No push occurs.
  - A simultaneous pop is discarded, with no side effect.
  - fetchPc <= redirectPc.
  - The state is unchanged, except for the FAULT transition.
- Redirect in IDLE updates fetchPc, so fetching resumes at the target.
- fetchEn=0 in FETCH: the current cycle does not capture. Entries already in the FIFO stay and remain poppable.
- Full FIFO with no pop: no push, and fetchPc holds, so the same address is re-read next cycle.

## Timing
- Reset values: fetchPc=RESET_PC, state=IDLE, FIFO empty, instrValid=0, instrOut=0, instrPc=0, fetchFault=0. instrMemAddr is RESET_PC.
- Latency: a capture at edge N makes instrValid=1 after edge N. Minimum fetch-to-decode latency is 1 cycle.
- Sustained throughput is 1 instruction per cycle when instrReady stays high.
- Redirect asserted in cycle C:
  - instrValid=0 after edge C.
  - instrMemAddr=redirectPc in cycle C+1.
  - The target instruction is valid after edge C+1.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first fetch occurs one cycle after release with fetchEn=1.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - redirectPc[1:0]≠0 does not change fetchPc, flushes the FIFO, enters FAULT and sets fetchFault=1.
  - fetchFault holds until reset.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirectPc[1:0] is forced to 2'b00.
  - fetchFault is tied to 0.
  - The FAULT state is unreachable and can be optimised out.

## Structure
- Package fetch_pkg holds:
  - the state enum (IDLE, FETCH, FAULT);
  - INSTR_BYTES=4;
  - the FIFO entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo:
  - synchronous FIFO of FIFO_DEPTH entries;
  - push/pop/flush inputs, full/empty outputs, head outputs;
  - pointers one bit wider than the index, for full/empty detection.
- Top level holds the FSM, the fetchPc register and redirect priority.

## Test plan
- Reset release, fetchEn=1, instrReady=1, memory words 0..3 = A,B,C,D: instrPc sequence 0,4,8,12 with A..D on consecutive cycles starting 1 cycle after the first FETCH cycle.
- instrReady=0 for 5 cycles after reset: FIFO fills to 2 entries (PC 0,4); instrMemAddr holds 8. Then instrReady=1: outputs 0,4,8 on consecutive cycles with no gap or duplicate.
- Redirect to 32'h40 while FIFO holds 2 entries and instrReady=1: the next cycle has instrValid=0 and instrMemAddr=32'h40; the following cycle has instrPc=32'h40.
- Redirect to 32'h42 with the macro defined: fetchFault=1, FIFO empty, and no further captures for 10 cycles. Same redirect without the macro: fetch resumes at 32'h40.
- Reset asserted mid-stream with 1 entry buffered: instrValid=0 and instrMemAddr=RESET_PC immediately, without a clock edge.
- RESET_PC=32'hFFFF_FFFC: second capture has instrPc=0, showing the wrap.
